// File: rtl/fb_oled_window.sv
// fb_oled_window
//   Frame-buffer to OLED pixel fetcher. Each destination pixel request (x, y)
//   is mapped to a source pixel through a frame-latched pan offset and a
//   compile-time decimation step. The frame buffer is read and a repacked
//   RGB565 colour is returned exactly 4 cycles after the request.
//
//   Ports:
//     clk, rst        single clock, synchronous active-high reset
//     pix_req, x, y   one-cycle pixel request and destination coordinates
//     off_x, off_y    window origin in source pixels (latched at frame start)
//     swap_r_b        swap red/blue fields (latched at frame start)
//     freeze          stop camera capture (latched at frame start)
//     test_pat        colour-bar test pattern select
//     fb_addr/fb_data frame-buffer read port, data valid 1 cycle after addr
//     color/color_valid  RGB565 result and its one-cycle strobe
//     capture_en      write-enable gate for the capture path
//
//   Optional feature: define FB_OLED_WIN_TESTPAT_EN to build the colour-bar
//   generator; otherwise test_pat is accepted but has no effect.
module fb_oled_window #(
  parameter int          SRC_COLS = 320,
  parameter int          SRC_ROWS = 240,
  parameter int          SRC_AW   = 17,
  parameter int          DST_XW   = 7,
  parameter int          OFF_XW   = 9,
  parameter int          STEP_X   = 3,
  parameter int          STEP_Y   = 3,
  parameter logic [15:0] BORDER   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_req,
  input  logic [DST_XW-1:0] x,
  input  logic [DST_XW-1:0] y,
  input  logic [OFF_XW-1:0] off_x,
  input  logic [OFF_XW-1:0] off_y,
  input  logic              swap_r_b,
  input  logic              freeze,
  input  logic              test_pat,
  output logic [SRC_AW-1:0] fb_addr,
  input  logic [15:0]       fb_data,
  output logic [15:0]       color,
  output logic              color_valid,
  output logic              capture_en
);

  localparam int SW = OFF_XW + 3;

  logic              frame_start;
  logic [OFF_XW-1:0] off_x_d, off_x_q, off_y_d, off_y_q;
  logic              swap_d, swap_q, freeze_d, freeze_q;
  // S1
  logic              v1_d, v1_q, oor1_d, oor1_q, swap1_d, swap1_q;
  logic [SW-1:0]     sx_d, sx_q, sy_d, sy_q;
  // S2
  logic              v2_d, v2_q, oor2_d, oor2_q, swap2_d, swap2_q;
  logic [SRC_AW-1:0] fb_addr_d, fb_addr_q;
  // S3
  logic              v3_d, v3_q, oor3_d, oor3_q, swap3_d, swap3_q;
  // S4
  logic [15:0]       color_d, color_q;
  logic              color_valid_d, color_valid_q;
  logic [4:0]        r5, b5;
  logic [5:0]        g6;

`ifdef FB_OLED_WIN_TESTPAT_EN
  logic       tp1_d, tp1_q, tp2_q, tp3_q;
  logic [2:0] bar1_d, bar1_q, bar2_q, bar3_q;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF; // white
      3'd1:    bar_color = 16'hFFE0; // yellow
      3'd2:    bar_color = 16'h07FF; // cyan
      3'd3:    bar_color = 16'h07E0; // green
      3'd4:    bar_color = 16'hF81F; // magenta
      3'd5:    bar_color = 16'hF800; // red
      3'd6:    bar_color = 16'h001F; // blue
      default: bar_color = 16'h0000; // black
    endcase
  endfunction
`endif

  always_comb begin
    // Frame registers: the next latched value doubles as the effective value
    // for the current request, so the frame-start pixel sees its own offsets.
    frame_start = pix_req && (x == '0) && (y == '0);
    off_x_d     = off_x_q;
    off_y_d     = off_y_q;
    swap_d      = swap_q;
    freeze_d    = freeze_q;
    if (frame_start) begin
      off_x_d  = off_x;
      off_y_d  = off_y;
      swap_d   = swap_r_b;
      freeze_d = freeze;
    end

    // S1: map
    v1_d    = pix_req;
    swap1_d = swap_d;
    sx_d    = SW'(off_x_d) + SW'(x) * SW'(STEP_X);
    sy_d    = SW'(off_y_d) + SW'(y) * SW'(STEP_Y);
    oor1_d  = (sx_d >= SW'(SRC_COLS)) || (sy_d >= SW'(SRC_ROWS));

    // S2: address; held on out-of-range pixels
    v2_d      = v1_q;
    oor2_d    = oor1_q;
    swap2_d   = swap1_q;
    fb_addr_d = fb_addr_q;
    if (v1_q && !oor1_q)
      fb_addr_d = SRC_AW'(sy_q) * SRC_AW'(SRC_COLS) + SRC_AW'(sx_q);

    // S3: RAM access in flight
    v3_d    = v2_q;
    oor3_d  = oor2_q;
    swap3_d = swap2_q;

    // S4: repack {r5, g5, b6} into RGB565
    r5            = fb_data[15:11];
    g6            = {fb_data[10:6], fb_data[10]};
    b5            = fb_data[5:1];
    color_valid_d = v3_q;
    color_d       = color_q;
    if (v3_q) begin
      if (oor3_q)       color_d = BORDER;
      else if (swap3_q) color_d = {b5, g6, r5};
      else              color_d = {r5, g6, b5};
`ifdef FB_OLED_WIN_TESTPAT_EN
      if (tp3_q) color_d = bar_color(bar3_q);
`endif
    end
  end

`ifdef FB_OLED_WIN_TESTPAT_EN
  assign tp1_d  = test_pat;
  assign bar1_d = x[DST_XW-1 -: 3];

  always_ff @(posedge clk) begin
    if (rst) begin
      tp1_q  <= 1'b0;
      tp2_q  <= 1'b0;
      tp3_q  <= 1'b0;
      bar1_q <= '0;
      bar2_q <= '0;
      bar3_q <= '0;
    end else begin
      tp1_q  <= tp1_d;
      tp2_q  <= tp1_q;
      tp3_q  <= tp2_q;
      bar1_q <= bar1_d;
      bar2_q <= bar1_q;
      bar3_q <= bar2_q;
    end
  end

  logic unused_bits;
  assign unused_bits = fb_data[0];
`else
  logic unused_bits;
  assign unused_bits = fb_data[0] ^ test_pat;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      off_x_q       <= '0;
      off_y_q       <= '0;
      swap_q        <= 1'b0;
      freeze_q      <= 1'b0;
      v1_q          <= 1'b0;
      oor1_q        <= 1'b0;
      swap1_q       <= 1'b0;
      sx_q          <= '0;
      sy_q          <= '0;
      v2_q          <= 1'b0;
      oor2_q        <= 1'b0;
      swap2_q       <= 1'b0;
      fb_addr_q     <= '0;
      v3_q          <= 1'b0;
      oor3_q        <= 1'b0;
      swap3_q       <= 1'b0;
      color_q       <= '0;
      color_valid_q <= 1'b0;
    end else begin
      off_x_q       <= off_x_d;
      off_y_q       <= off_y_d;
      swap_q        <= swap_d;
      freeze_q      <= freeze_d;
      v1_q          <= v1_d;
      oor1_q        <= oor1_d;
      swap1_q       <= swap1_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      v2_q          <= v2_d;
      oor2_q        <= oor2_d;
      swap2_q       <= swap2_d;
      fb_addr_q     <= fb_addr_d;
      v3_q          <= v3_d;
      oor3_q        <= oor3_d;
      swap3_q       <= swap3_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign color       = color_q;
  assign color_valid = color_valid_q;
  assign capture_en  = ~freeze_q;

endmodule

// File: tb/tb_fb_oled_window.sv
module tb_fb_oled_window;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_req = 1'b0;
  logic [6:0]  x = '0, y = '0;
  logic [8:0]  off_x = '0, off_y = '0;
  logic        swap_r_b = 1'b0, freeze = 1'b0, test_pat = 1'b0;
  logic [16:0] fb_addr;
  logic [15:0] fb_data = '0;
  logic [15:0] color;
  logic        color_valid, capture_en;

  fb_oled_window dut (
    .clk(clk), .rst(rst), .pix_req(pix_req), .x(x), .y(y),
    .off_x(off_x), .off_y(off_y), .swap_r_b(swap_r_b), .freeze(freeze),
    .test_pat(test_pat), .fb_addr(fb_addr), .fb_data(fb_data),
    .color(color), .color_valid(color_valid), .capture_en(capture_en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-buffer model: synchronous read, data one cycle after address.
  logic        dmode  = 1'b0;
  logic [15:0] dconst = '0;

  function automatic logic [15:0] hash(input logic [16:0] a);
    hash = {a[7:0], a[15:8]} ^ {a[16], 15'h2B5D};
  endfunction

  always @(posedge clk) fb_data <= dmode ? hash(fb_addr) : dconst;

  function automatic logic [15:0] pack(input logic [15:0] d, input logic sw);
    logic [4:0] r, b;
    logic [5:0] g;
    r = d[15:11];
    g = {d[10:6], d[10]};
    b = d[5:1];
    pack = sw ? {b, g, r} : {r, g, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single isolated request: address after 2 cycles, strobe exactly at 4.
  task automatic req_full(input logic [6:0] rx, input logic [6:0] ry,
                          input logic [16:0] ea, input string name);
    x = rx; y = ry; pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    tick();
    chk({name, "_addr"}, fb_addr, ea);
    tick();
    chk({name, "_cv_early"}, color_valid, 0);
    tick();
    chk({name, "_cv"}, color_valid, 1);
    tick();
  endtask

  // Stream scoreboard
  logic        sb_en = 1'b0;
  logic [15:0] exp_q[$];
  int          got = 0, first_cyc = 0, last_cyc = 0;

  always @(negedge clk) begin
    if (sb_en && color_valid) begin
      got++;
      if (got == 1) first_cyc = cyc;
      last_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_extra: got color %0h expected no pulse", color);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (color !== e) begin
          n_fail++;
          $display("FAIL stream_color[%0d]: got %0h expected %0h", got - 1, color, e);
        end
      end
    end
  end

  typedef struct {
    logic [8:0]  ox, oy;
    logic [6:0]  vx, vy;
    logic        sw;
    logic [15:0] d;
    logic [16:0] ea;
    logic [15:0] ec;
  } vec_t;

  vec_t vt[10];

  initial begin
    int start_cyc;

    //          ox   oy   vx   vy  sw  fb_data   addr    color
    vt[0] = '{9'd10,  9'd5,   7'd2,   7'd1, 1'b0, 16'hFFFF, 17'd2576,  16'hFFFF};
    vt[1] = '{9'd300, 9'd0,   7'd7,   7'd0, 1'b0, 16'hFFFF, 17'd300,   16'h0000};
    vt[2] = '{9'd300, 9'd0,   7'd6,   7'd0, 1'b0, 16'h1234, 17'd318,   16'h121A};
    vt[3] = '{9'd0,   9'd0,   7'd1,   7'd1, 1'b1, 16'hF800, 17'd963,   16'h001F};
    vt[4] = '{9'd1,   9'd0,   7'd106, 7'd0, 1'b0, 16'h07C0, 17'd319,   16'h07E0};
    vt[5] = '{9'd2,   9'd0,   7'd106, 7'd0, 1'b0, 16'hFFFF, 17'd2,     16'h0000};
    vt[6] = '{9'd0,   9'd236, 7'd0,   7'd1, 1'b0, 16'hABCD, 17'd76480, 16'hABC6};
    vt[7] = '{9'd0,   9'd237, 7'd0,   7'd1, 1'b0, 16'hFFFF, 17'd75840, 16'h0000};
    vt[8] = '{9'd400, 9'd0,   7'd0,   7'd0, 1'b0, 16'hFFFF, 17'd75840, 16'h0000};
    vt[9] = '{9'd0,   9'd0,   7'd0,   7'd2, 1'b1, 16'hABCD, 17'd1920,  16'h33D5};

    // Reset then single request
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_addr", fb_addr, 0);
    chk("rst_color", color, 0);
    chk("rst_cv", color_valid, 0);
    chk("rst_capture_en", capture_en, 1);
    dconst = 16'hFFFF;
    x = 0; y = 0; pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    chk("first_cv_n1", color_valid, 0);
    tick();
    chk("first_addr", fb_addr, 0);
    chk("first_cv_n2", color_valid, 0);
    tick();
    chk("first_cv_n3", color_valid, 0);
    tick();
    chk("first_cv_n4", color_valid, 1);
    chk("first_color", color, 16'hFFFF);
    chk("first_capture_en", capture_en, 1);
    tick();
    chk("first_cv_n5", color_valid, 0);
    chk("first_color_hold", color, 16'hFFFF);
    tick();

    // Table-driven vectors: frame start carrying the offsets, then the pixel
    for (int i = 0; i < 10; i++) begin
      off_x = vt[i].ox; off_y = vt[i].oy; swap_r_b = vt[i].sw;
      dmode = 1'b0; dconst = vt[i].d;
      x = 0; y = 0; pix_req = 1'b1;
      tick();
      x = vt[i].vx; y = vt[i].vy;
      tick();
      pix_req = 1'b0;
      tick();
      chk($sformatf("vec%0d_addr", i), fb_addr, vt[i].ea);
      tick(); tick();
      chk($sformatf("vec%0d_cv", i), color_valid, 1);
      chk($sformatf("vec%0d_color", i), color, vt[i].ec);
      tick(); tick();
    end
    swap_r_b = 1'b0;

    // Mid-frame offset change is ignored until the next frame start
    off_x = 0; off_y = 0;
    req_full(0, 0, 0, "mid_fs0");
    off_x = 50;
    req_full(1, 0, 3, "mid_px");
    req_full(0, 0, 50, "mid_fs1");
    req_full(1, 0, 53, "mid_px2");

    // Freeze raised mid-frame takes effect at the next frame start
    off_x = 0; freeze = 1'b0;
    req_full(0, 0, 0, "frz_fs0");
    freeze = 1'b1;
    req_full(1, 0, 3, "frz_px");
    chk("frz_mid_capture_en", capture_en, 1);
    x = 0; y = 0; pix_req = 1'b1;
    chk("frz_pre_capture_en", capture_en, 1);
    tick();
    pix_req = 1'b0;
    chk("frz_post_capture_en", capture_en, 0);
    tick(); tick(); tick(); tick();

    // Throughput: 96 back-to-back requests
    freeze = 1'b0; off_x = 5; off_y = 2; swap_r_b = 1'b0; dmode = 1'b1;
    got = 0;
    sb_en = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < 96; i++) begin
      logic [16:0] a;
      x = 7'(i % 32); y = 7'(i / 32); pix_req = 1'b1;
      a = 17'((2 + 3 * (i / 32)) * 320 + 5 + 3 * (i % 32));
      exp_q.push_back(pack(hash(a), 1'b0));
      tick();
    end
    pix_req = 1'b0;
    for (int t = 0; t < 50 && got < 96; t++) tick();
    tick(); tick();
    sb_en = 1'b0;
    chk("stream_count", got, 96);
    chk("stream_first_latency", first_cyc - start_cyc, 4);
    chk("stream_contiguous", last_cyc - first_cyc, 95);
    chk("stream_capture_en", capture_en, 1);
    exp_q.delete();

    // Reset flush: rst two cycles into a stream, with a request during rst
    dmode = 1'b0; dconst = 16'h1234; off_x = 0; off_y = 0; freeze = 1'b1;
    x = 0; y = 0; pix_req = 1'b1;
    tick();
    x = 1;
    tick();
    rst = 1'b1; x = 2;
    tick();
    tick();
    rst = 1'b0; pix_req = 1'b0;
    for (int t = 0; t < 10; t++) begin
      chk($sformatf("flush_cv%0d", t), color_valid, 0);
      tick();
    end
    chk("flush_capture_en", capture_en, 1);
    off_x = 77;
    req_full(1, 0, 3, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
